// File: rtl/pc_unit.sv
// Program counter for the MIPS-lite datapath: sequential, branch, jump and
// register-jump redirects with stall and an optional branch delay slot.
module pc_unit #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
  parameter int              OFFSET_BITS  = 16,
  parameter bit              DELAY_SLOT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_mode,
  input  logic [25:0]      imm,
  input  logic [WIDTH-1:0] reg_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             slot_pending,
  output logic             misaligned
);

  typedef enum logic {RUN = 1'b0, SLOT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] latched, latched_nxt;
  logic             mis_nxt;
  logic             accept;
  logic [WIDTH-1:0] branch_sext;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] reg_tgt;
  logic [WIDTH-1:0] target;

  assign pc_plus4    = pc + WIDTH'(4);
  assign branch_sext = {{(WIDTH-OFFSET_BITS){imm[OFFSET_BITS-1]}}, imm[OFFSET_BITS-1:0]};
  assign branch_tgt  = pc_plus4 + {branch_sext[WIDTH-3:0], 2'b00};
  assign reg_tgt     = {reg_target[WIDTH-1:2], 2'b00};

  // At exactly 28 bits the jump field covers the whole address.
  generate
    if (WIDTH > 28) begin : g_jump_wide
      assign jump_tgt = {pc_plus4[WIDTH-1:28], imm, 2'b00};
    end else begin : g_jump_narrow
      assign jump_tgt = {imm, 2'b00};
    end
  endgenerate

  always_comb begin
    target = pc_plus4;
    case (redirect_mode)
      2'b01:   target = branch_tgt;
      2'b10:   target = jump_tgt;
      2'b11:   target = reg_tgt;
      default: target = pc_plus4;
    endcase
  end

  // Mode 00 is plain sequential flow, so it never opens a delay slot.
  assign accept = redirect_valid && (redirect_mode != 2'b00) && !stall && (state == RUN);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    latched_nxt = latched;
    mis_nxt     = 1'b0;
    if (!stall) begin
      if (state == SLOT) begin
        pc_nxt    = latched;
        state_nxt = RUN;
      end else if (accept) begin
        mis_nxt = (redirect_mode == 2'b11) && (reg_target[1:0] != 2'b00);
        if (DELAY_SLOT) begin
          latched_nxt = target;
          pc_nxt      = pc_plus4;
          state_nxt   = SLOT;
        end else begin
          pc_nxt = target;
        end
      end else begin
        pc_nxt = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VECTOR;
      state      <= RUN;
      latched    <= '0;
      misaligned <= 1'b0;
    end else begin
      pc         <= pc_nxt;
      state      <= state_nxt;
      latched    <= latched_nxt;
      misaligned <= mis_nxt;
    end
  end

  assign slot_pending = DELAY_SLOT && (state == SLOT);

endmodule

// File: tb/tb_pc_unit.sv
// Drives a no-delay-slot and a delay-slot pc_unit with shared stimulus and
// compares both against a queue-based reference of the architectural PC.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [1:0]  redirect_mode;
  logic [25:0] imm;
  logic [31:0] reg_target;

  logic [31:0] pc0, pc_plus4_0, pc1, pc_plus4_1;
  logic        slot0, slot1, mis0, mis1;

  int errors = 0;
  int checks = 0;

  logic [31:0] m0_pc, m1_pc;
  logic        m0_mis, m1_mis;
  logic [31:0] m1_pending[$];

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(32), .RESET_VECTOR(RV), .OFFSET_BITS(16), .DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_mode(redirect_mode), .imm(imm), .reg_target(reg_target),
    .pc(pc0), .pc_plus4(pc_plus4_0), .slot_pending(slot0), .misaligned(mis0));

  pc_unit #(.WIDTH(32), .RESET_VECTOR(RV), .OFFSET_BITS(16), .DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_mode(redirect_mode), .imm(imm), .reg_target(reg_target),
    .pc(pc1), .pc_plus4(pc_plus4_1), .slot_pending(slot1), .misaligned(mis1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] target_of(input logic [31:0] p, input logic [1:0] mode,
                                            input logic [25:0] im, input logic [31:0] rt);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    off = int'($signed(im[15:0])) * 4;
    case (mode)
      2'b01:   return seq + 32'(off);
      2'b10:   return {seq[31:28], im, 2'b00};
      2'b11:   return rt & 32'hFFFF_FFFC;
      default: return seq;
    endcase
  endfunction

  // One clock: advance reference, wait for edge, compare both DUTs.
  task automatic tick();
    logic        take;
    logic [31:0] tgt;
    take = redirect_valid && (redirect_mode != 2'b00);
    tgt  = target_of(m0_pc, redirect_mode, imm, reg_target);
    if (rst) begin
      m0_pc = RV; m1_pc = RV; m0_mis = 0; m1_mis = 0;
      m1_pending.delete();
    end else if (stall) begin
      m0_mis = 0; m1_mis = 0;
    end else begin
      m0_mis = take && redirect_mode == 2'b11 && reg_target[1:0] != 0;
      m0_pc  = take ? tgt : m0_pc + 32'd4;
      if (m1_pending.size() != 0) begin
        m1_pc  = m1_pending.pop_front();
        m1_mis = 0;
      end else begin
        tgt    = target_of(m1_pc, redirect_mode, imm, reg_target);
        m1_mis = take && redirect_mode == 2'b11 && reg_target[1:0] != 0;
        if (take) m1_pending.push_back(tgt);
        m1_pc  = m1_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    chk("pc0", pc0, m0_pc);
    chk("pc_plus4_0", pc_plus4_0, m0_pc + 32'd4);
    chk("slot0", {31'd0, slot0}, 32'd0);
    chk("mis0", {31'd0, mis0}, {31'd0, m0_mis});
    chk("pc1", pc1, m1_pc);
    chk("pc_plus4_1", pc_plus4_1, m1_pc + 32'd4);
    chk("slot1", {31'd0, slot1}, {31'd0, (m1_pending.size() != 0)});
    chk("mis1", {31'd0, mis1}, {31'd0, m1_mis});
  endtask

  task automatic drive(input logic r, input logic s, input logic v, input logic [1:0] m,
                       input logic [25:0] i, input logic [31:0] t);
    rst = r; stall = s; redirect_valid = v; redirect_mode = m; imm = i; reg_target = t;
  endtask

  initial begin
    m0_pc = RV; m1_pc = RV; m0_mis = 0; m1_mis = 0;
    drive(1, 0, 0, 2'b00, '0, '0);
    tick();
    chk("t1_reset_pc", pc0, 32'h3000);
    chk("t1_reset_slot", {31'd0, slot1}, 32'd0);

    // Free-running sequence
    drive(0, 0, 0, 2'b00, '0, '0);
    tick(); chk("t1_pc1", pc0, 32'h3004);
    tick(); chk("t1_pc2", pc0, 32'h3008);
    tick(); chk("t1_pc3", pc0, 32'h300C);
    chk("t1_plus4", pc_plus4_0, 32'h3010);
    tick(); chk("t2_start", pc0, 32'h3010);

    // Branch backward then forward
    drive(0, 0, 1, 2'b01, 26'h000FFFE, '0);
    tick(); chk("t2_back", pc0, 32'h300C);
    drive(0, 0, 1, 2'b01, 26'h0000003, '0);
    tick(); chk("t2_fwd", pc0, 32'h301C);
    drive(0, 0, 0, 2'b00, '0, '0);
    tick(); chk("t3_start", pc0, 32'h3020);

    // Absolute jump then misaligned register jump
    drive(0, 0, 1, 2'b10, 26'h0000C10, '0);
    tick(); chk("t3_jump", pc0, 32'h3040);
    drive(0, 0, 1, 2'b11, '0, 32'h0000_4006);
    tick(); chk("t3_regjump", pc0, 32'h4004);
    chk("t3_mis_hi", {31'd0, mis0}, 32'd1);
    drive(0, 0, 0, 2'b00, '0, '0);
    tick(); chk("t3_mis_lo", {31'd0, mis0}, 32'd0);

    // Stall holds a pending branch
    drive(1, 0, 0, 2'b00, '0, '0);
    tick();
    drive(0, 1, 1, 2'b01, 26'd4, '0);
    repeat (3) begin
      tick(); chk("t4_hold", pc0, 32'h3000);
    end
    drive(0, 0, 1, 2'b01, 26'd4, '0);
    tick(); chk("t4_release", pc0, 32'h3014);
    chk("t5_slot_pc", pc1, 32'h3004);
    chk("t5_slot_flag", {31'd0, slot1}, 32'd1);
    tick(); chk("t5_ignore", pc1, 32'h3014);

    // Stall inside the delay slot
    drive(1, 0, 0, 2'b00, '0, '0);
    tick();
    drive(0, 0, 1, 2'b01, 26'd4, '0);
    tick(); chk("t5b_slot", pc1, 32'h3004);
    drive(0, 1, 0, 2'b00, '0, '0);
    repeat (2) begin
      tick(); chk("t5b_hold", pc1, 32'h3004);
    end
    drive(0, 0, 0, 2'b00, '0, '0);
    tick(); chk("t5b_target", pc1, 32'h3014);

    // Wrap at the top of the address space
    drive(0, 0, 1, 2'b11, '0, 32'hFFFF_FFFC);
    tick(); chk("t6_top0", pc0, 32'hFFFF_FFFC);
    chk("t6_plus4_wrap", pc_plus4_0, 32'h0);
    drive(0, 0, 0, 2'b00, '0, '0);
    tick(); chk("t6_wrap0", pc0, 32'h0);
    chk("t6_top1", pc1, 32'hFFFF_FFFC);
    tick(); chk("t6_wrap1", pc1, 32'h0);

    // Reset while stalled in the slot
    drive(0, 0, 1, 2'b01, 26'd8, '0);
    tick(); chk("t6_in_slot", {31'd0, slot1}, 32'd1);
    drive(1, 1, 0, 2'b00, '0, '0);
    tick(); chk("t6_rst_pc", pc1, 32'h3000);
    chk("t6_rst_slot", {31'd0, slot1}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), 26'($urandom), $urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the MIPS-lite datapath.
- Owns the architectural PC register; computes and applies the next PC each cycle.
- Supports four redirect modes: sequential, PC-relative branch, absolute jump, register jump.
- Adds pipeline stall and an optional one-instruction branch delay slot. Sits between the control unit and instruction memory.

Parameters:
WIDTH, 32, PC/address width in bits (>= 28)
RESET_VECTOR, 32'h0000_3000, PC value loaded on reset
OFFSET_BITS, 16, width of the branch immediate field, sign-extended then shifted left 2
DELAY_SLOT, 0, 0 = redirect takes effect next cycle; 1 = one delay-slot instruction executes first

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  freeze PC and internal state this cycle
redirect_valid  input  1  current instruction requests a non-sequential PC
redirect_mode  input  2  00 seq, 01 branch rel, 10 jump abs, 11 jump register
imm  input  26  immediate field; branch uses [OFFSET_BITS-1:0], jump uses [25:0]
reg_target  input  WIDTH  target address for mode 11
pc  output  WIDTH  current PC (registered)
pc_plus4  output  WIDTH  pc + 4, combinational, link value
slot_pending  output  1  high while PC addresses a delay-slot instruction (DELAY_SLOT=1 only)
misaligned  output  1  one-cycle pulse: accepted register target had [1:0] != 0

Behaviour:
- Reset (rst=1 at clk edge, overrides stall): pc=RESET_VECTOR, state RUN, slot_pending=0, misaligned=0, latched target=0.
- Arithmetic modulo 2^WIDTH. pc_plus4 = pc + 4 wraps silently.
- Target calculation from the pc of the accepting cycle:
  - branch: pc + 4 + (sext(imm[OFFSET_BITS-1:0]) << 2)
  - jump: {pc_plus4[WIDTH-1:28], imm[25:0], 2'b00}
  - register: {reg_target[WIDTH-1:2], 2'b00}
- Mode 00 with redirect_valid=1 is sequential (pc+4).
- A redirect is accepted only when redirect_valid=1, stall=0, and state=RUN.
- stall=1: pc, state, latched target hold; misaligned=0; inputs ignored. Caller holds redirect inputs until stall drops.
- misaligned: asserted the cycle after accepting mode 11 with reg_target[1:0]!=0. The jump still proceeds to the aligned address.
- DELAY_SLOT=0 (state always RUN):
  - Accepted redirect: pc <= target on the next edge.
  - Otherwise: pc <= pc+4.
  - slot_pending is tied 0.
- DELAY_SLOT=1, two-state FSM:
  - RUN, accept: latch target, pc <= pc+4, go to SLOT. slot_pending=1 while in SLOT.
  - RUN, no accept: pc <= pc+4.
  - SLOT, stall=0: pc <= latched target, go to RUN. redirect_valid in SLOT is ignored; a branch in a delay slot is architecturally undefined and dropped.
  - SLOT, stall=1: hold in SLOT.
- Reset mid-SLOT: the pending target is discarded; pc=RESET_VECTOR.
- Latency: redirect visible on pc 1 cycle after acceptance (DELAY_SLOT=0) or 2 cycles after, excluding stalled cycles (DELAY_SLOT=1).

Test Plan:
1. Reset then 3 free cycles, DELAY_SLOT=0 -> pc 0x3000, 0x3004, 0x3008, 0x300C; pc_plus4 tracks pc+4.
2. DELAY_SLOT=0 at pc=0x3010:
   - branch, imm=16'hFFFE -> next pc 0x300C.
   - Then branch, imm=16'h0003 -> 0x301C.
3. DELAY_SLOT=0 at pc=0x3020:
   - jump, imm=26'h0000C10 -> pc 0x0000_3040.
   - Then reg jump, reg_target=0x0000_4006 -> pc 0x4004, misaligned pulses exactly one cycle.
4. Stall: hold stall=1 for 3 cycles with redirect_valid=1 (branch, imm=4) at pc=0x3000 -> pc stays 0x3000; after release, next pc 0x3014.
5. DELAY_SLOT=1, branch imm=4 at pc=0x3000:
   - pc sequence 0x3004 (slot_pending=1), then 0x3014.
   - A redirect asserted during the slot is ignored.
   - Stall during the slot delays 0x3014 by the stall length.
6. Wrap and reset:
   - pc near 2^WIDTH-4 wraps to 0x0000_0000.
   - rst asserted in SLOT with stall=1 -> pc=0x3000, slot_pending=0 next cycle.
